// File: rtl/contador_banco_param_if.sv
// Readback port of the counter bank: request/index in, registered response out.
// Latency: response valid one cycle after request acceptance; not a pipeline stage itself.
// Backpressure: busy high while a read is in flight; req during busy is dropped.
// Signals: req/idx (master->slave); data/ovf/err/valid/busy (slave->master).
interface contador_banco_param_if #(
  parameter int IDX_W = 3,
  parameter int CNT_W = 5
);
  logic             req;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] data;
  logic             ovf;
  logic             err;
  logic             valid;
  logic             busy;

  modport master (
    output req, idx,
    input  data, ovf, err, valid, busy
  );

  modport slave (
    input  req, idx,
    output data, ovf, err, valid, busy
  );
endinterface

// File: rtl/contador_banco_param.sv
// Bank of NUM_CH event counters (wrap or saturate, sticky overflow) polled by index.
// Latency: req accepted at edge N, valid high for one cycle from edge N+1; one read per 3 cycles.
// Backpressure: busy in S_CAP/S_RESP; req seen while busy is dropped, never queued.
// Ports: clk, reset (async active-low), inc[NUM_CH] per-channel strobes, idle freezes
// counting only, rd = readback interface (slave modport).
// Optional feature: define CONTADOR_CLR_ON_READ_EN for clear-on-read of the channel read.
module contador_banco_param #(
  parameter int NUM_CH   = 5,
  parameter int CNT_W    = 5,
  parameter int IDX_W    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] inc,
  input  logic              idle,
  contador_banco_param_if.slave rd
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAP  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [NUM_CH-1:0] ovf_flag_q;

  logic [CNT_W-1:0]  sel_cnt;
  logic              sel_ovf;
  logic              in_range;
  logic              accept;
  logic [NUM_CH-1:0] clr_vec;

  logic [CNT_W-1:0]  snap_cnt;
  logic              snap_ovf;
  logic              snap_err;
  logic [CNT_W-1:0]  data_q;
  logic              ovf_q;
  logic              err_q;

  assign accept   = (state_q == S_IDLE) && rd.req;
  // Extra bit so the compare still works when NUM_CH == 2**IDX_W.
  assign in_range = ({1'b0, rd.idx} < (IDX_W + 1)'(NUM_CH));

  // Read mux over the pre-edge counter state; an out-of-range index selects nothing
  // and therefore yields zeros, which is exactly the error response payload.
  always_comb begin
    sel_cnt = '0;
    sel_ovf = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd.idx == IDX_W'(k)) begin
        sel_cnt = cnt_q[k];
        sel_ovf = ovf_flag_q[k];
      end
    end
  end

`ifdef CONTADOR_CLR_ON_READ_EN
  always_comb begin
    clr_vec = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      clr_vec[k] = accept && in_range && (rd.idx == IDX_W'(k));
    end
  end
`else
  assign clr_vec = '0;
`endif

  // Counters. A clear-on-read that coincides with an increment keeps that event
  // (loads 1), since the snapshot only reports the pre-edge value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= '0;
      end
      ovf_flag_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (clr_vec[k]) begin
          cnt_q[k]      <= (!idle && inc[k]) ? CNT_W'(1) : '0;
          ovf_flag_q[k] <= 1'b0;
        end else if (!idle && inc[k]) begin
          if (&cnt_q[k]) begin
            ovf_flag_q[k] <= 1'b1;
            cnt_q[k]      <= SATURATE ? cnt_q[k] : '0;
          end else begin
            cnt_q[k] <= cnt_q[k] + CNT_W'(1);
          end
        end
      end
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = rd.req ? S_CAP : S_IDLE;
      S_CAP:   state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. Decoded from the state so a reset drops them without a clock.
  always_comb begin
    rd.valid = (state_q == S_RESP);
    rd.busy  = (state_q != S_IDLE);
  end

  // Snapshot at acceptance, response registers loaded on leaving S_CAP; the
  // response registers hold their value after valid drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_cnt <= '0;
      snap_ovf <= 1'b0;
      snap_err <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        snap_cnt <= sel_cnt;
        snap_ovf <= sel_ovf;
        snap_err <= !in_range;
      end
      if (state_q == S_CAP) begin
        data_q <= snap_cnt;
        ovf_q  <= snap_ovf;
        err_q  <= snap_err;
      end
    end
  end

  assign rd.data = data_q;
  assign rd.ovf  = ovf_q;
  assign rd.err  = err_q;

endmodule

// File: tb/tb_contador_banco_param.sv
// Directed bench for contador_banco_param: a wrapping and a saturating instance
// driven with identical stimulus; responses packed as {valid, err, ovf, data}.
module tb_contador_banco_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] inc;
  logic       idle;
  logic       req;
  logic [2:0] idx;

  int n_tests = 0;
  int n_fail  = 0;
  int nv;
  int nb;

  always #5 clk = ~clk;

  contador_banco_param_if #(.IDX_W(3), .CNT_W(5)) rd_w ();
  contador_banco_param_if #(.IDX_W(3), .CNT_W(5)) rd_s ();

  assign rd_w.req = req;
  assign rd_w.idx = idx;
  assign rd_s.req = req;
  assign rd_s.idx = idx;

  contador_banco_param #(.NUM_CH(5), .CNT_W(5), .IDX_W(3), .SATURATE(1'b0)) u_wrap (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .idle  (idle),
    .rd    (rd_w)
  );

  contador_banco_param #(.NUM_CH(5), .CNT_W(5), .IDX_W(3), .SATURATE(1'b1)) u_sat (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .idle  (idle),
    .rd    (rd_s)
  );

  logic [7:0] resp_w;
  logic [7:0] resp_s;
  assign resp_w = {rd_w.valid, rd_w.err, rd_w.ovf, rd_w.data};
  assign resp_s = {rd_s.valid, rd_s.err, rd_s.ovf, rd_s.data};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // n counted increments on the channels in mask, with the given idle level.
  task automatic pulse(input logic [4:0] mask, input int n, input logic idl);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      inc  = mask;
      idle = idl;
    end
    @(posedge clk); #1;
    inc  = '0;
    idle = 1'b0;
  endtask

  task automatic read_ch(input logic [2:0] i, input string tag,
                         input logic [7:0] exp_w, input logic [7:0] exp_s);
    @(posedge clk); #1;
    req = 1'b1;
    idx = i;
    @(posedge clk); #1;
    req = 1'b0;
    check({tag, "_busy"}, 32'(rd_w.busy), 32'd1);
    @(posedge clk); #1;
    check({tag, "_wrap"}, 32'(resp_w), 32'(exp_w));
    check({tag, "_sat"}, 32'(resp_s), 32'(exp_s));
    @(posedge clk); #1;
    check({tag, "_vdrop"}, 32'(resp_w), 32'(exp_w & 8'h7f));
  endtask

  initial begin
    reset = 1'b0;
    inc   = '0;
    idle  = 1'b0;
    req   = 1'b0;
    idx   = '0;
    #3;
    check("rst_resp_w", 32'(resp_w), 32'd0);
    check("rst_resp_s", 32'(resp_s), 32'd0);
    check("rst_busy", 32'(rd_w.busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      read_ch(3'(i), $sformatf("rst_rd%0d", i), 8'h80, 8'h80);
    end

    pulse(5'b00100, 7, 1'b0);
    read_ch(3'd2, "ch2_seven", 8'h87, 8'h87);
    read_ch(3'd1, "ch1_zero", 8'h80, 8'h80);

    pulse(5'b00001, 33, 1'b0);
    read_ch(3'd0, "ch0_ovf", 8'hA1, 8'hBF);

    pulse(5'b01000, 4, 1'b1);
    pulse(5'b01000, 2, 1'b0);
    read_ch(3'd3, "ch3_idle", 8'h82, 8'h82);

    // req held high: accept, CAP, RESP repeats every 3 cycles.
    @(posedge clk); #1;
    req = 1'b1;
    idx = 3'd3;
    nv = 0;
    nb = 0;
    repeat (9) begin
      @(negedge clk);
      nv += int'(rd_w.valid);
      nb += int'(rd_w.busy);
    end
    req = 1'b0;
    check("held_valid_pulses", 32'(nv), 32'd3);
    check("held_busy_cycles", 32'(nb), 32'd6);
    repeat (2) @(posedge clk);

    read_ch(3'd6, "idx_oor", 8'hC0, 8'hC0);

    // Reset pulsed while in S_CAP.
    @(posedge clk); #1;
    req = 1'b1;
    idx = 3'd2;
    @(posedge clk); #1;
    req = 1'b0;
    check("mid_busy_pre", 32'(rd_w.busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_busy_drop", 32'(rd_w.busy), 32'd0);
    check("mid_resp_clr", 32'(resp_w), 32'd0);
    nv = 0;
    repeat (2) begin
      @(negedge clk);
      nv += int'(rd_w.valid) + int'(rd_s.valid);
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      nv += int'(rd_w.valid) + int'(rd_s.valid);
    end
    check("mid_no_valid", 32'(nv), 32'd0);
    read_ch(3'd2, "post_rst_ch2", 8'h80, 8'h80);
    read_ch(3'd0, "post_rst_ch0", 8'h80, 8'h80);

    // Five events on ch4, then a read accepted on an edge that also increments.
    pulse(5'b10000, 5, 1'b0);
    @(posedge clk); #1;
    req = 1'b1;
    idx = 3'd4;
    inc = 5'b10000;
    @(posedge clk); #1;
    req = 1'b0;
    inc = '0;
    @(posedge clk); #1;
    check("ch4_first", 32'(resp_w), 32'h85);
    @(posedge clk); #1;
`ifdef CONTADOR_CLR_ON_READ_EN
    read_ch(3'd4, "ch4_second", 8'h81, 8'h81);
`else
    read_ch(3'd4, "ch4_second", 8'h86, 8'h86);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/contador_banco_param.md
# contador_banco_param

Parametrised bank of NUM_CH independent event counters with a single request/response readback port. Successor to the fixed five-counter-plus-selector arrangement in the counters test area: channel count and widths are generics, counters support wrap or saturate, and each has a sticky overflow flag. Sits between per-channel event strobes and the probador/monitor side, which polls counts by index.

## Interface
- NUM_CH, 5, number of counter channels (1..2**IDX_W)
- CNT_W, 5, counter width in bits
- IDX_W, 3, width of channel index
- SATURATE, 0, 0 = counters wrap modulo 2**CNT_W; 1 = counters hold at all-ones
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately
- inc  in  NUM_CH  per-channel increment strobe, bit k drives channel k
- idle  in  1  high = freeze all counting; reads still serviced
- req  in  1  read request, sampled only when busy = 0
- idx  in  IDX_W  channel to read, sampled with req
- data  out  CNT_W  read result
- ovf  out  1  overflow flag of the channel read
- err  out  1  idx out of range (idx >= NUM_CH)
- valid  out  1  data/ovf/err qualifier
- busy  out  1  read in progress; req ignored

## Operation
- Reset values: all counters 0, all overflow flags 0, FSM = S_IDLE, data = 0, ovf = 0, err = 0, valid = 0, busy = 0.
- Counting, per channel k, each edge: if idle = 0 and inc[k] = 1 then count[k] + 1; otherwise hold.
- Overflow: increment from all-ones sets ovf_flag[k] (sticky). SATURATE = 0: count goes to 0. SATURATE = 1: count stays all-ones; flag still set.
- FSM states: S_IDLE, S_CAP, S_RESP.
  - S_IDLE: req = 1 -> S_CAP; snapshot count[idx], ovf_flag[idx] (pre-edge values) and range check.
  - S_CAP: unconditional -> S_RESP; load data/ovf/err from snapshot, valid = 1.
  - S_RESP: unconditional -> S_IDLE; valid = 0.
- busy = 1 in S_CAP and S_RESP.
- Out of range: err = 1, data = 0, ovf = 0, no counter affected.
- data/ovf/err hold last response value after valid drops.
- idle does not affect FSM; only counting.

## Timing
- req sampled at edge N (state S_IDLE). Snapshot excludes any increment taken at edge N.
- valid = 1 between edge N+1 and edge N+2 (one cycle); read latency 1 cycle after acceptance.
- Maximum read rate: one request accepted every 3 cycles; req during busy is dropped, not queued.
- Reset asserted mid-read: FSM returns to S_IDLE, valid/busy drop immediately without waiting for clk.
- Simultaneous increment on all channels in one cycle is legal; each channel independent.

## Configuration
- CONTADOR_CLR_ON_READ_EN defined: at acceptance edge N of an in-range read, count[idx] loads (idle = 0 and inc[idx] = 1) ? 1 : 0 and ovf_flag[idx] clears; snapshot still returns pre-clear values, so no event is lost or double-counted. Out-of-range reads clear nothing.
- Undefined: reads are non-destructive; counters and flags change only via counting and reset.

## Test plan
- Reset then read idx 0..4 -> each response valid = 1 one cycle, data = 0, ovf = 0, err = 0.
- 7 cycles of inc[2] = 1, then read idx 2 -> data = 7; read idx 1 -> data = 0.
- SATURATE = 0, CNT_W = 5, 33 increments on channel 0 -> data = 1, ovf = 1; SATURATE = 1 same stimulus -> data = 31, ovf = 1.
- idle = 1 for 4 cycles with inc[3] = 1, then idle = 0 for 2 cycles -> read idx 3 returns 2; req held high during busy -> exactly one valid pulse per 3 cycles.
- Read idx 6 with NUM_CH = 5 -> err = 1, data = 0; reset pulsed in S_CAP -> valid never asserts, busy = 0 at once.
- CONTADOR_CLR_ON_READ_EN: count 5 on channel 4, read with inc[4] = 1 at acceptance edge -> response 5, second read returns 1.
